// File: rtl/chunked_adder_seq.sv
// Wide adder sequencer: feeds one external 5-bit ripple adder a chunk per clock,
// chaining the carry through a register, LSB chunk first.
module chunked_adder_seq #(
  parameter int unsigned CHUNKS  = 4,
  parameter int unsigned CHUNK_W = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CHUNKS*CHUNK_W-1:0]   op_a,
  input  logic [CHUNKS*CHUNK_W-1:0]   op_b,
  input  logic                        cin_in,
  output logic [CHUNK_W-1:0]          add_a,
  output logic [CHUNK_W-1:0]          add_b,
  output logic                        add_cin,
  input  logic [CHUNK_W-1:0]          add_sum,
  input  logic                        add_cout,
  output logic                        busy,
  output logic                        done,
  output logic [CHUNKS*CHUNK_W-1:0]   result,
  output logic                        carry_out,
  output logic                        overflow
);

  localparam int unsigned W     = CHUNKS * CHUNK_W;
  localparam int unsigned IDX_W = $clog2(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [31:0]      base;

  assign base = CHUNK_W * 32'(idx);

  // Adder operands come from registers only, so there is no loop through the adder.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = CHUNK_W'(a_reg >> base);
      add_b   = CHUNK_W'(b_reg >> base);
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry     <= cin_in;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < CHUNKS; k++) begin
            if (idx == IDX_W'(k)) result[k*CHUNK_W +: CHUNK_W] <= add_sum;
          end
          carry <= add_cout;
          idx   <= idx + 1'b1;
          // Final chunk: its sum MSB is the result sign bit.
          if (idx == LAST_IDX) begin
            carry_out <= add_cout;
            overflow  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[CHUNK_W-1] != a_reg[W-1]);
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Scoreboard bench for chunked_adder_seq: CHUNKS=4 and CHUNKS=2 instances, each
// wrapped around a behavioural 5-bit adder, checked against a plain-arithmetic model.
module tb_chunked_adder_seq;

  typedef struct packed { logic [20:0] sum; logic ovf; } exp4_t;
  typedef struct packed { logic [10:0] sum; logic ovf; } exp2_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- CHUNKS=4 instance ----------------
  logic        rst_n, start, cin_in;
  logic [19:0] op_a, op_b, result;
  logic [4:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout, busy, done, carry_out, overflow;

  assign {add_cout, add_sum} = 6'(add_a) + 6'(add_b) + 6'(add_cin);

  chunked_adder_seq #(.CHUNKS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow));

  // ---------------- CHUNKS=2 instance ----------------
  logic        rst_n2, start2, cin_in2;
  logic [9:0]  op_a2, op_b2, result2;
  logic [4:0]  add_a2, add_b2, add_sum2;
  logic        add_cin2, add_cout2, busy2, done2, carry_out2, overflow2;

  assign {add_cout2, add_sum2} = 6'(add_a2) + 6'(add_b2) + 6'(add_cin2);

  chunked_adder_seq #(.CHUNKS(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .start(start2), .op_a(op_a2), .op_b(op_b2), .cin_in(cin_in2),
    .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2), .add_sum(add_sum2), .add_cout(add_cout2),
    .busy(busy2), .done(done2), .result(result2), .carry_out(carry_out2), .overflow(overflow2));

  exp4_t q4[$];
  exp2_t q2[$];
  int    done_cnt4 = 0;
  int    done_cnt2 = 0;
  logic  prev_done4 = 1'b0;
  logic  prev_done2 = 1'b0;
  bit    fin2 = 1'b0;

  int         last_busy;
  logic [7:0] last_cins;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: unbounded integer add, then signed range test for overflow.
  function automatic void model(input longint a, input longint b, input longint c, input int w,
                                output longint sum, output logic ovf);
    longint half, sa, sb, s;
    half = longint'(1) << (w - 1);
    sum  = a + b + c;
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    s    = sa + sb + c;
    ovf  = (s >= half) || (s < -half);
  endfunction

  task automatic push4(input logic [19:0] a, input logic [19:0] b, input logic c);
    longint s;
    logic   o;
    model(longint'(a), longint'(b), longint'(c), 20, s, o);
    q4.push_back('{sum: 21'(s), ovf: o});
  endtask

  // Monitors: pop an expectation on every done pulse.
  always @(negedge clk) begin
    if (done) begin
      chk("done4_single_cycle", 64'(prev_done4), 64'd0);
      if (q4.size() == 0) begin
        chk("done4_unexpected", 64'd1, 64'd0);
      end else begin
        exp4_t e;
        e = q4.pop_front();
        chk("sum4", 64'({carry_out, result}), 64'(e.sum));
        chk("ovf4", 64'(overflow), 64'(e.ovf));
        chk("busy4_low_at_done", 64'(busy), 64'd0);
      end
      done_cnt4++;
    end
    prev_done4 <= done;
  end

  always @(negedge clk) begin
    if (done2) begin
      chk("done2_single_cycle", 64'(prev_done2), 64'd0);
      if (q2.size() == 0) begin
        chk("done2_unexpected", 64'd1, 64'd0);
      end else begin
        exp2_t e;
        e = q2.pop_front();
        chk("sum2", 64'({carry_out2, result2}), 64'(e.sum));
        chk("ovf2", 64'(overflow2), 64'(e.ovf));
      end
      done_cnt2++;
    end
    prev_done2 <= done2;
  end

  // Wait (bounded) for the next done on dut4, recording busy cycles and add_cin per RUN cycle.
  task automatic wait_done4(input string nm);
    int  n0;
    bit  got;
    n0 = done_cnt4;
    got = 1'b0;
    last_busy = 0;
    last_cins = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt4 != n0) got = 1'b1;
      else if (busy) begin
        last_busy++;
        last_cins = {last_cins[6:0], add_cin};
      end
    end
    if (!got) chk({nm, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic do_op(input logic [19:0] a, input logic [19:0] b, input logic c);
    @(posedge clk);
    #1;
    start = 1'b1; op_a = a; op_b = b; cin_in = c;
    push4(a, b, c);
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = 20'($urandom); op_b = 20'($urandom); cin_in = 1'($urandom);
    wait_done4("op");
  endtask

  function automatic logic [19:0] rnd20();
    case ($urandom_range(0, 7))
      0: return 20'hFFFFF;
      1: return 20'h80000;
      2: return 20'h7FFFF;
      default: return 20'($urandom);
    endcase
  endfunction

  // CHUNKS=2 random stream.
  initial begin
    longint s;
    logic   o;
    int     n0;
    bit     got;
    rst_n2 = 1'b0; start2 = 1'b0; op_a2 = '0; op_b2 = '0; cin_in2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst2_result", 64'(result2), 64'd0);
    chk("rst2_busy", 64'(busy2), 64'd0);
    rst_n2 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      start2 = 1'b1;
      op_a2 = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom);
      op_b2 = 10'($urandom);
      cin_in2 = 1'($urandom);
      model(longint'(op_a2), longint'(op_b2), longint'(cin_in2), 10, s, o);
      q2.push_back('{sum: 11'(s), ovf: o});
      n0 = done_cnt2;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      op_a2 = 10'($urandom); op_b2 = 10'($urandom);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        #1;
        if (done_cnt2 != n0) got = 1'b1;
      end
      if (!got) chk("op2_timeout", 64'd1, 64'd0);
    end
    fin2 = 1'b1;
  end

  // CHUNKS=4 directed and random sequence.
  initial begin
    int n0;
    bit got;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({carry_out, overflow}), 64'd0);
    chk("rst_adder_in", 64'({add_a, add_b, add_cin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(20'h03039, 20'h0D431, 1'b0);
    chk("t1_busy_cycles", 64'(last_busy), 64'd4);
    chk("t1_result", 64'(result), 64'h1046A);
    chk("t1_flags", 64'({carry_out, overflow}), 64'd0);

    do_op(20'hFFFFF, 20'h00001, 1'b0);
    chk("t2_cin_cycles2to4", 64'(last_cins[2:0]), 64'h7);
    chk("t2_cin_cycle1", 64'(last_cins[3]), 64'd0);
    chk("t2_sum", 64'({carry_out, result}), 64'h100000);

    do_op(20'h7FFFF, 20'h00000, 1'b1);
    chk("t3a_result", 64'(result), 64'h80000);
    chk("t3a_flags", 64'({carry_out, overflow}), 64'h1);
    do_op(20'h80000, 20'h80000, 1'b0);
    chk("t3b_sum", 64'({carry_out, result}), 64'h100000);
    chk("t3b_ovf", 64'(overflow), 64'd1);

    // Starts during RUN and DONE must be ignored.
    @(posedge clk);
    #1;
    start = 1'b1; op_a = 20'h12345; op_b = 20'h0ABCD; cin_in = 1'b1;
    push4(20'h12345, 20'h0ABCD, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1; op_a = 20'hFFFFF; op_b = 20'hFFFFF; cin_in = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n0 = done_cnt4;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt4 != n0) got = 1'b1;
    end
    if (!got) chk("t4_timeout", 64'd1, 64'd0);
    start = 1'b1; op_a = 20'h00001; op_b = 20'h00001;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("t4_busy_after_done", 64'(busy), 64'd0);
    chk("t4_result_held", 64'({carry_out, result}), 64'h1CF13);
    do_op(20'h54321, 20'h11111, 1'b0);
    chk("t4_second_result", 64'(result), 64'h65432);

    // Asynchronous reset in RUN cycle 3 aborts the operation.
    @(posedge clk);
    #1;
    start = 1'b1; op_a = 20'hABCDE; op_b = 20'h12345; cin_in = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_result", 64'(result), 64'd0);
    chk("t5_outs", 64'({done, carry_out, overflow, add_a, add_b, add_cin}), 64'd0);
    n0 = done_cnt4;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_no_done", 64'(done_cnt4 - n0), 64'd0);
    do_op(20'h0F0F0, 20'h01010, 1'b1);
    chk("t5_fresh_result", 64'(result), 64'h10101);

    for (int i = 0; i < 1000; i++) do_op(rnd20(), rnd20(), 1'($urandom));

    got = fin2;
    for (int k = 0; k < 20000 && !got; k++) begin
      @(posedge clk);
      got = fin2;
    end
    if (!got) chk("dut2_stream_timeout", 64'd1, 64'd0);
    repeat (4) @(posedge clk);
    chk("q4_drained", 64'(q4.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
